bsg_cache_non_blocking_dma_initiator: RTL and testbench
=======================================================

// Module: bsg_cache_non_blocking_dma_initiator
// PURPOSE
//  Initiator end of the non-blocking cache DMA interface. Takes one line-fill (read) or
//  line-evict (write) request, issues a dma_pkt, and moves a full block between an internal
//  line buffer and the DMA data channels. Returns a completion carrying the filled line.
//  Sits between the miss-handling logic and a DMA responder (memory model or real backend).
// PARAMETERS
//  addr_width_p           (none)  byte address width; also the dma_pkt addr field width
//  data_width_p           (none)  DMA word width in bits; multiple of 8
//  block_size_in_words_p  (none)  words per cache line; >=1
//  block_width_lp   = data_width_p*block_size_in_words_p
//  dma_pkt_width_lp = `bsg_cache_non_blocking_dma_pkt_width(addr_width_p)
// PORTS
//  clk_i                 in   1                 clock
//  reset_n_i             in   1                 async reset, active low
//  req_v_i               in   1                 request valid
//  req_ready_o           out  1                 request accepted when req_v_i & req_ready_o
//  req_write_not_read_i  in   1                 1=evict line, 0=fill line
//  req_addr_i            in   addr_width_p      any byte address inside the line
//  req_block_i           in   block_width_lp    evict data; word0 at bits [data_width_p-1:0]
//  resp_v_o              out  1                 completion valid (read and write)
//  resp_write_not_read_o out  1                 type of completed request
//  resp_block_o          out  block_width_lp    filled line (reads); line buffer contents (writes)
//  resp_yumi_i           in   1                 completion consumed
//  dma_pkt_o             out  dma_pkt_width_lp  bsg_cache_non_blocking_dma_pkt_s {write_not_read, addr}
//  dma_pkt_v_o           out  1                 packet valid
//  dma_pkt_yumi_i        in   1                 packet taken
//  dma_data_i            in   data_width_p      fill data word
//  dma_data_v_i          in   1                 fill word valid
//  dma_data_ready_o      out  1                 fill word accepted when dma_data_v_i & ready
//  dma_data_o            out  data_width_p      evict data word
//  dma_data_v_o          out  1                 evict word valid
//  dma_data_yumi_i       in   1                 evict word taken
// BEHAVIOUR
//  Reset (reset_n_i=0, asynchronous): state IDLE, word counter 0, line buffer 0, address/flag regs 0.
//   During and after reset: resp_v_o, dma_pkt_v_o, dma_data_v_o, dma_data_ready_o = 0; req_ready_o = 1
//   once reset_n_i=1. Reset asserted mid-operation aborts instantly; no partial handshake completes.
//  All outputs are decoded from registered state (no comb path from *_i valid/yumi to *_v_o).
//  FSM:
//   IDLE:  req_ready_o=1. On req_v_i: latch flag, aligned addr, req_block_i (writes only) -> SEND_PKT.
//   SEND_PKT: dma_pkt_v_o=1, pkt held stable until dma_pkt_yumi_i; then counter=0 ->
//             RECV (read) or SEND_DATA (write). Write data never precedes packet acceptance.
//   RECV:  dma_data_ready_o=1; each dma_data_v_i writes buffer word[counter], counter++.
//          Word at counter==block_size_in_words_p-1 -> RESP.
//   SEND_DATA: dma_data_v_o=1, dma_data_o=buffer word[counter]; each dma_data_yumi_i counter++;
//          yumi at last word -> RESP. dma_data_o stable while not yumi'd.
//   RESP:  resp_v_o=1, resp_block_o=buffer; on resp_yumi_i -> IDLE (req_ready_o=1 next cycle).
//  Latency (zero-stall responder): read = 1 (pkt) + N words + 1 resp cycle after acceptance;
//   write identical with N evict words. One request in flight; req_ready_o=0 outside IDLE.
//  Address: dma_pkt addr = req_addr_i with low lg(data_width_p/8)+lg(block_size_in_words_p)
//   bits forced to 0.
//  Counter: `BSG_SAFE_CLOG2(block_size_in_words_p) bits; last-word compare, never wraps silently;
//   block_size_in_words_p=1 -> exactly one data beat.
//  Simultaneous: in RESP, resp_yumi_i with req_v_i does not accept the new req (accepted next cycle).
//  Data-channel inputs ignored outside RECV; yumi ignored outside SEND_PKT/SEND_DATA.
// TESTING (data_width_p=32, block_size_in_words_p=4, addr_width_p=32 unless noted)
//  1 Fill: req addr 0x104 rd -> dma_pkt {wnr=0,addr=0x100}; feed A0..A3 -> resp_block_o={A3,A2,A1,A0}.
//  2 Evict: req addr 0x12C wr, block {D3,D2,D1,D0} -> pkt {1,0x120}; dma_data_o D0,D1,D2,D3 in order,
//    dma_data_v_o low until pkt yumi; resp_v_o with resp_write_not_read_o=1.
//  3 Backpressure: pkt yumi delayed 5 cycles, random gaps on dma_data_v_i / dma_data_yumi_i ->
//    pkt and dma_data_o stable, counter advances only on handshakes, same final line.
//  4 Resp stall: resp_yumi_i low 3 cycles with req_v_i=1 -> resp_v_o held, req_ready_o=0, no accept.
//  5 Reset after 2 fill words -> all valids/ready 0 immediately; post-release req_ready_o=1, new fill
//    of B0..B3 returns {B3,B2,B1,B0} with no stale words.
//  6 block_size_in_words_p=1: fill and evict each complete with exactly one data beat.

Source files
------------

// File: rtl/bsg_cache_non_blocking_dma_initiator.sv
// Initiator side of the non-blocking cache DMA interface: one line fill or evict at a time,
// moved word by word between a line buffer and the DMA data channels.
module bsg_cache_non_blocking_dma_initiator #(
  parameter int unsigned addr_width_p          = 32,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 4,
  localparam int unsigned block_width_lp       = data_width_p * block_size_in_words_p,
  localparam int unsigned dma_pkt_width_lp     = addr_width_p + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic                        req_v_i,
  output logic                        req_ready_o,
  input  logic                        req_write_not_read_i,
  input  logic [addr_width_p-1:0]     req_addr_i,
  input  logic [block_width_lp-1:0]   req_block_i,

  output logic                        resp_v_o,
  output logic                        resp_write_not_read_o,
  output logic [block_width_lp-1:0]   resp_block_o,
  input  logic                        resp_yumi_i,

  output logic [dma_pkt_width_lp-1:0] dma_pkt_o,
  output logic                        dma_pkt_v_o,
  input  logic                        dma_pkt_yumi_i,

  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_ready_o,

  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_yumi_i
);

  localparam int unsigned CntWidthLp =
    (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
  localparam int unsigned OffsetWidthLp =
    $clog2(data_width_p / 8) + $clog2(block_size_in_words_p);
  localparam logic [CntWidthLp-1:0]   LastCntLp  = CntWidthLp'(block_size_in_words_p - 1);
  localparam logic [addr_width_p-1:0] AddrMaskLp =
    ~(addr_width_p'((64'd1 << OffsetWidthLp) - 64'd1));

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSendPkt  = 3'd1;
  localparam logic [2:0] StRecv     = 3'd2;
  localparam logic [2:0] StSendData = 3'd3;
  localparam logic [2:0] StResp     = 3'd4;

  logic [2:0]                r_state, w_state_d;
  logic [CntWidthLp-1:0]     r_cnt,   w_cnt_d;
  logic [block_width_lp-1:0] r_buf,   w_buf_d;
  logic [addr_width_p-1:0]   r_addr,  w_addr_d;
  logic                      r_wnr,   w_wnr_d;
  logic                      w_last;
  int unsigned               w_base;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_buf_d   = r_buf;
    w_addr_d  = r_addr;
    w_wnr_d   = r_wnr;
    w_last    = (r_cnt == LastCntLp);
    w_base    = 32'(r_cnt) * data_width_p;
    unique case (r_state)
      StIdle: begin
        if (req_v_i) begin
          w_wnr_d  = req_write_not_read_i;
          w_addr_d = req_addr_i & AddrMaskLp;
          if (req_write_not_read_i) w_buf_d = req_block_i;
          w_state_d = StSendPkt;
        end
      end
      StSendPkt: begin
        if (dma_pkt_yumi_i) begin
          w_cnt_d   = '0;
          w_state_d = r_wnr ? StSendData : StRecv;
        end
      end
      StRecv: begin
        if (dma_data_v_i) begin
          w_buf_d[w_base +: data_width_p] = dma_data_i;
          // Counter saturates at the last word; leaving the state ends the beat sequence.
          if (w_last) w_state_d = StResp;
          else        w_cnt_d   = r_cnt + 1'b1;
        end
      end
      StSendData: begin
        if (dma_data_yumi_i) begin
          if (w_last) w_state_d = StResp;
          else        w_cnt_d   = r_cnt + 1'b1;
        end
      end
      StResp: begin
        if (resp_yumi_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_wnr   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_buf   <= w_buf_d;
      r_addr  <= w_addr_d;
      r_wnr   <= w_wnr_d;
    end
  end

  // Ready is additionally gated by reset so nothing looks acceptable while reset is held.
  assign req_ready_o           = reset_n_i & (r_state == StIdle);
  assign dma_pkt_v_o           = (r_state == StSendPkt);
  assign dma_pkt_o             = {r_wnr, r_addr};
  assign dma_data_ready_o      = (r_state == StRecv);
  assign dma_data_v_o          = (r_state == StSendData);
  assign dma_data_o            = r_buf[w_base +: data_width_p];
  assign resp_v_o              = (r_state == StResp);
  assign resp_write_not_read_o = r_wnr;
  assign resp_block_o          = r_buf;

endmodule

// File: tb/tb_bsg_cache_non_blocking_dma_initiator.sv
// Randomized scoreboard bench for the DMA initiator, plus a directed one-word-line instance.
module tb_bsg_cache_non_blocking_dma_initiator;

  typedef struct packed {
    logic         wnr;
    logic [127:0] blk;
  } resp_t;

  logic clk, reset_n;

  logic         req_v, req_ready, req_wnr;
  logic [31:0]  req_addr;
  logic [127:0] req_block;
  logic         resp_v, resp_wnr, resp_yumi;
  logic [127:0] resp_block;
  logic [32:0]  pkt;
  logic         pkt_v, pkt_yumi;
  logic [31:0]  data_i, data_o;
  logic         data_v_i, data_ready, data_v_o, data_yumi;

  logic         req_v1, req_ready1, req_wnr1;
  logic [31:0]  req_addr1, req_block1, resp_block1;
  logic         resp_v1, resp_wnr1, resp_yumi1;
  logic [32:0]  pkt1;
  logic         pkt_v1, pkt_yumi1;
  logic [31:0]  data_i1, data_o1;
  logic         data_v_i1, data_ready1, data_v_o1, data_yumi1;

  logic [32:0] exp_pkt_q[$];
  logic [31:0] exp_evict_q[$];
  logic [31:0] fill_q[$];
  resp_t       exp_resp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int outstanding = 0;
  int fill_beats  = 0;
  bit pkt_done = 0;
  bit in_reset = 1;
  int pkt_wait = 0, pkt_target = 5, resp_wait = 0, resp_target = 3;

  bsg_cache_non_blocking_dma_initiator #(
    .addr_width_p(32), .data_width_p(32), .block_size_in_words_p(4)
  ) u_dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_write_not_read_i(req_wnr),
    .req_addr_i(req_addr), .req_block_i(req_block),
    .resp_v_o(resp_v), .resp_write_not_read_o(resp_wnr), .resp_block_o(resp_block),
    .resp_yumi_i(resp_yumi),
    .dma_pkt_o(pkt), .dma_pkt_v_o(pkt_v), .dma_pkt_yumi_i(pkt_yumi),
    .dma_data_i(data_i), .dma_data_v_i(data_v_i), .dma_data_ready_o(data_ready),
    .dma_data_o(data_o), .dma_data_v_o(data_v_o), .dma_data_yumi_i(data_yumi)
  );

  bsg_cache_non_blocking_dma_initiator #(
    .addr_width_p(32), .data_width_p(32), .block_size_in_words_p(1)
  ) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v1), .req_ready_o(req_ready1), .req_write_not_read_i(req_wnr1),
    .req_addr_i(req_addr1), .req_block_i(req_block1),
    .resp_v_o(resp_v1), .resp_write_not_read_o(resp_wnr1), .resp_block_o(resp_block1),
    .resp_yumi_i(resp_yumi1),
    .dma_pkt_o(pkt1), .dma_pkt_v_o(pkt_v1), .dma_pkt_yumi_i(pkt_yumi1),
    .dma_data_i(data_i1), .dma_data_v_i(data_v_i1), .dma_data_ready_o(data_ready1),
    .dma_data_o(data_o1), .dma_data_v_o(data_v_o1), .dma_data_yumi_i(data_yumi1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: line address is the byte address rounded down to a 16-byte line.
  function automatic logic [32:0] exp_pkt(input logic wnr, input logic [31:0] addr);
    return {wnr, (addr / 32'd16) * 32'd16};
  endfunction

  task automatic issue(input logic wnr, input logic [31:0] addr, input logic [127:0] blk,
                       input logic [127:0] fill);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    req_v = 1'b1; req_wnr = wnr; req_addr = addr; req_block = blk;
    #1;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("req_accept", 160'(req_ready), 160'd1);
    if (req_ready) begin
      exp_pkt_q.push_back(exp_pkt(wnr, addr));
      for (int i = 0; i < 4; i++) begin
        if (wnr) exp_evict_q.push_back(blk[i*32 +: 32]);
        else     fill_q.push_back(fill[i*32 +: 32]);
      end
      exp_resp_q.push_back(resp_t'{wnr: wnr, blk: wnr ? blk : fill});
      @(posedge clk);
      #1;
    end
    req_v = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((outstanding != 0 || exp_resp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 160'(t < 3000), 160'd1);
  endtask

  function automatic logic [127:0] rand_line();
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Responder: randomized handshakes, with junk on channels that should be ignored.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pkt_yumi = 0; data_v_i = 0; data_yumi = 0; resp_yumi = 0;
        pkt_wait = 0; resp_wait = 0;
      end else begin
        if (pkt_v) begin
          pkt_yumi = (pkt_wait >= pkt_target);
          if (pkt_yumi) begin
            pkt_wait = 0;
            pkt_target = $urandom_range(0, 5);
          end else pkt_wait++;
        end else pkt_yumi = ($urandom_range(0, 3) == 0);
        if (data_ready && fill_q.size() > 0) begin
          data_v_i = ($urandom_range(0, 2) != 0);
          if (data_v_i) begin
            data_i = fill_q.pop_front();
            fill_beats++;
          end else data_i = $urandom;
        end else begin
          data_v_i = data_ready ? 1'b0 : 1'($urandom_range(0, 1));
          data_i   = $urandom;
        end
        data_yumi = data_v_o ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
        if (resp_v) begin
          resp_yumi = (resp_wait >= resp_target);
          if (resp_yumi) begin
            resp_wait = 0;
            resp_target = $urandom_range(0, 3);
          end else resp_wait++;
        end else resp_yumi = 1'b0;
      end
    end
  end

  // Monitor: compares every presented output against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && !in_reset) begin
        check("req_ready", 160'(req_ready), 160'(outstanding == 0));
        if (pkt_v) begin
          if (exp_pkt_q.size() == 0) check("pkt_unexpected", 160'(pkt), 160'h0 - 1);
          else begin
            check("pkt", 160'(pkt), 160'(exp_pkt_q[0]));
            if (pkt_yumi) begin
              void'(exp_pkt_q.pop_front());
              pkt_done = 1;
            end
          end
        end
        if (data_ready) check("fill_before_pkt", 160'(pkt_done), 160'd1);
        if (data_v_o) begin
          check("evict_before_pkt", 160'(pkt_done), 160'd1);
          if (exp_evict_q.size() == 0) check("evict_unexpected", 160'(data_o), 160'h0 - 1);
          else begin
            check("evict_word", 160'(data_o), 160'(exp_evict_q[0]));
            if (data_yumi) void'(exp_evict_q.pop_front());
          end
        end
        if (resp_v) begin
          check("resp_early", 160'(exp_evict_q.size() + fill_q.size()), 160'd0);
          if (exp_resp_q.size() == 0) check("resp_unexpected", 160'(resp_block), 160'h0 - 1);
          else begin
            check("resp", 160'({resp_wnr, resp_block}), 160'(exp_resp_q[0]));
            if (resp_yumi) begin
              void'(exp_resp_q.pop_front());
              outstanding--;
              pkt_done = 0;
            end
          end
        end
        if (req_v && req_ready) outstanding++;
      end
    end
  end

  task automatic run1(input logic wnr, input logic [31:0] addr, input logic [31:0] word);
    int beats = 0;
    bit done  = 0;
    @(negedge clk);
    req_v1 = 1'b1; req_wnr1 = wnr; req_addr1 = addr; req_block1 = word;
    #1;
    check("b1_ready", 160'(req_ready1), 160'd1);
    @(negedge clk);
    req_v1 = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      if (pkt_v1)    check("b1_pkt", 160'(pkt1), 160'({wnr, (addr / 32'd4) * 32'd4}));
      if (data_v_o1) check("b1_evict", 160'(data_o1), 160'(word));
      if (resp_v1) begin
        check("b1_resp", 160'({resp_wnr1, resp_block1}), 160'({wnr, word}));
        check("b1_beats", 160'(beats), 160'd1);
        done = 1;
      end
      pkt_yumi1 = pkt_v1; data_v_i1 = data_ready1; data_i1 = word;
      data_yumi1 = data_v_o1; resp_yumi1 = resp_v1;
      beats += int'((data_ready1 & data_v_i1) | (data_v_o1 & data_yumi1));
      @(negedge clk);
    end
    pkt_yumi1 = 0; data_v_i1 = 0; data_yumi1 = 0; resp_yumi1 = 0;
    check("b1_done", 160'(done), 160'd1);
  endtask

  initial begin
    logic [127:0] line_a, line_d;
    int t;
    reset_n = 1'b0;
    req_v = 0; req_wnr = 0; req_addr = 0; req_block = 0;
    pkt_yumi = 0; data_v_i = 0; data_i = 0; data_yumi = 0; resp_yumi = 0;
    req_v1 = 0; req_wnr1 = 0; req_addr1 = 0; req_block1 = 0; resp_yumi1 = 0;
    pkt_yumi1 = 0; data_i1 = 0; data_v_i1 = 0; data_yumi1 = 0;
    #1;
    check("rst_outputs", 160'({req_ready, resp_v, pkt_v, data_v_o, data_ready}), 160'd0);
    check("rst_pkt", 160'(pkt), 160'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    in_reset = 0;
    #1;
    check("post_rst_ready", 160'(req_ready), 160'd1);

    for (int i = 0; i < 4; i++) line_a[i*32 +: 32] = 32'hA000_0000 + i;
    for (int i = 0; i < 4; i++) line_d[i*32 +: 32] = 32'hD000_0000 + i;
    issue(1'b0, 32'h104, 128'd0, line_a);
    issue(1'b1, 32'h12C, line_d, 128'd0);
    for (int n = 0; n < 30; n++) issue(1'($urandom_range(0, 1)), $urandom, rand_line(), rand_line());
    drain();

    // Reset in the middle of a fill, after two words have been taken.
    fill_beats = 0;
    issue(1'b0, 32'h2000, 128'd0, rand_line());
    t = 0;
    while (fill_beats < 2 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("partial_fill", 160'(fill_beats >= 2), 160'd1);
    @(posedge clk);
    #2;
    in_reset = 1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", 160'({req_ready, resp_v, pkt_v, data_v_o, data_ready}), 160'd0);
    exp_pkt_q.delete(); exp_evict_q.delete(); fill_q.delete(); exp_resp_q.delete();
    outstanding = 0;
    pkt_done = 0;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    in_reset = 0;
    #1;
    check("rerst_ready", 160'(req_ready), 160'd1);
    for (int i = 0; i < 4; i++) line_a[i*32 +: 32] = 32'hB000_0000 + i;
    issue(1'b0, 32'h2008, 128'd0, line_a);
    drain();

    run1(1'b0, 32'h37, 32'hCAFE_0001);
    run1(1'b1, 32'h5A, 32'hBEEF_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
